// File: rtl/gpio_ctrl_core.sv
// GPIO controller core: register file, pad-input synchronizers with edge-detect interrupts,
// and a walking-ones pad test mode.
module gpio_ctrl_core #(
    parameter int unsigned gpio_width = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [2:0]            addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    output logic                  rd_valid,
    input  logic                  tm,
    input  logic [gpio_width-1:0] pad_y,
    output logic [gpio_width-1:0] pad_a,
    output logic [gpio_width-1:0] pad_oe,
    output logic                  irq
);

    localparam logic [2:0] addr_data_out   = 3'd0;
    localparam logic [2:0] addr_dir        = 3'd1;
    localparam logic [2:0] addr_data_in    = 3'd2;
    localparam logic [2:0] addr_irq_en     = 3'd3;
    localparam logic [2:0] addr_irq_status = 3'd4;
    localparam logic [2:0] addr_edge_sel   = 3'd5;

    localparam logic [gpio_width-1:0] lane_one = gpio_width'(1);

    logic [gpio_width-1:0] data_out_q, data_out_d;
    logic [gpio_width-1:0] dir_q, dir_d;
    logic [gpio_width-1:0] irq_en_q, irq_en_d;
    logic [gpio_width-1:0] irq_status_q, irq_status_d;
    logic [gpio_width-1:0] edge_sel_q, edge_sel_d;
    logic [gpio_width-1:0] s1_q, s2_q, s3_q;
    logic [gpio_width-1:0] pattern_q, pattern_d;
    logic                  tm_s1_q, tm_s_q;
    logic [15:0]           rdata_q, rdata_d;
    logic                  rd_valid_q;

    logic [gpio_width-1:0] wdata_lane;
    logic [gpio_width-1:0] edge_hit;
    logic [gpio_width-1:0] w1c;
    logic [15:0]           rd_mux;

    // Bits of wdata above gpio_width are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    always_comb begin
        wdata_lane   = wdata[gpio_width-1:0];
        data_out_d   = data_out_q;
        dir_d        = dir_q;
        irq_en_d     = irq_en_q;
        edge_sel_d   = edge_sel_q;
        w1c          = '0;
        if (wr_en) begin
            case (addr)
                addr_data_out:   data_out_d = wdata_lane;
                addr_dir:        dir_d      = wdata_lane;
                addr_irq_en:     irq_en_d   = wdata_lane;
                addr_irq_status: w1c        = wdata_lane;
                addr_edge_sel:   edge_sel_d = wdata_lane;
                default:         ;
            endcase
        end

        edge_hit = (edge_sel_q & s2_q & ~s3_q) | (~edge_sel_q & ~s2_q & s3_q);
        // A new edge beats a same-cycle W1C; test mode blocks new sets only.
        irq_status_d = (irq_status_q & ~w1c) | (tm_s_q ? '0 : edge_hit);

        pattern_d = tm_s_q ? ((pattern_q << 1) | (pattern_q >> (gpio_width - 1))) : lane_one;

        rd_mux = '0;
        case (addr)
            addr_data_out:   rd_mux[gpio_width-1:0] = data_out_q;
            addr_dir:        rd_mux[gpio_width-1:0] = dir_q;
            addr_data_in:    rd_mux[gpio_width-1:0] = s2_q;
            addr_irq_en:     rd_mux[gpio_width-1:0] = irq_en_q;
            addr_irq_status: rd_mux[gpio_width-1:0] = irq_status_q;
            addr_edge_sel:   rd_mux[gpio_width-1:0] = edge_sel_q;
            default:         ;
        endcase
        rdata_d = rd_en ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_status_q <= '0;
            edge_sel_q   <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            tm_s1_q      <= 1'b0;
            tm_s_q       <= 1'b0;
            pattern_q    <= lane_one;
            rdata_q      <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            irq_status_q <= irq_status_d;
            edge_sel_q   <= edge_sel_d;
            s1_q         <= pad_y;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            tm_s1_q      <= tm;
            tm_s_q       <= tm_s1_q;
            pattern_q    <= pattern_d;
            rdata_q      <= rdata_d;
            rd_valid_q   <= rd_en;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign pad_a    = tm_s_q ? pattern_q : data_out_q;
    assign pad_oe   = tm_s_q ? '1 : dir_q;
    assign irq      = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_ctrl_core.sv
// Directed bench for gpio_ctrl_core: register table, edge interrupts, W1C race,
// test-mode walking ones, async reset and read/write collisions.
module tb_gpio_ctrl_core;

    localparam int W = 15;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, tm, rd_valid, irq;
    logic [2:0]    addr;
    logic [15:0]   wdata, rdata;
    logic [W-1:0]  pad_y, pad_a, pad_oe;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [15:0] exp_rd;
        logic [15:0] exp_pa;
        logic [15:0] exp_oe;
    } vec_t;

    vec_t vecs[12];

    gpio_ctrl_core #(.gpio_width(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .tm       (tm),
        .pad_y    (pad_y),
        .pad_a    (pad_a),
        .pad_oe   (pad_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] rotl15(input logic [15:0] v);
        return ((v << 1) | (v >> 14)) & 16'h7FFF;
    endfunction

    initial begin
        logic [15:0] exp_pat;

        vecs[0]  = '{3'd1, 16'h00FF, 3'd1, 16'h00FF, 16'h0000, 16'h00FF};
        vecs[1]  = '{3'd0, 16'h0055, 3'd0, 16'h0055, 16'h0055, 16'h00FF};
        vecs[2]  = '{3'd0, 16'hFFFF, 3'd0, 16'h7FFF, 16'h7FFF, 16'h00FF};
        vecs[3]  = '{3'd2, 16'h1234, 3'd2, 16'h0000, 16'h7FFF, 16'h00FF};
        vecs[4]  = '{3'd6, 16'hFFFF, 3'd6, 16'h0000, 16'h7FFF, 16'h00FF};
        vecs[5]  = '{3'd7, 16'hFFFF, 3'd7, 16'h0000, 16'h7FFF, 16'h00FF};
        vecs[6]  = '{3'd5, 16'h8001, 3'd5, 16'h0001, 16'h7FFF, 16'h00FF};
        vecs[7]  = '{3'd3, 16'h0F0F, 3'd3, 16'h0F0F, 16'h7FFF, 16'h00FF};
        vecs[8]  = '{3'd4, 16'h7FFF, 3'd4, 16'h0000, 16'h7FFF, 16'h00FF};
        vecs[9]  = '{3'd1, 16'h1234, 3'd1, 16'h1234, 16'h7FFF, 16'h1234};
        vecs[10] = '{3'd0, 16'h0055, 3'd0, 16'h0055, 16'h0055, 16'h1234};
        vecs[11] = '{3'd1, 16'h00FF, 3'd1, 16'h00FF, 16'h0055, 16'h00FF};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; tm = 1'b0; pad_y = '0;
        cycles(2);
        check("reset_pad_a", {1'b0, pad_a}, 16'h0000);
        check("reset_pad_oe", {1'b0, pad_oe}, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_rd_valid", {15'b0, rd_valid}, 16'h0000);
        rst = 1'b0;
        cycles(1);

        // Register table: write then read back, with pad outputs tracked per row.
        for (int i = 0; i < 12; i++) begin
            do_write(vecs[i].wa, vecs[i].wd);
            do_read(vecs[i].ra);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_rd_valid", i), {15'b0, rd_valid}, 16'h0001);
            check($sformatf("vec%0d_pad_a", i), {1'b0, pad_a}, vecs[i].exp_pa);
            check($sformatf("vec%0d_pad_oe", i), {1'b0, pad_oe}, vecs[i].exp_oe);
            check($sformatf("vec%0d_irq", i), {15'b0, irq}, 16'h0000);
        end
        cycles(1);
        check("rd_valid_pulse", {15'b0, rd_valid}, 16'h0000);
        check("rdata_hold", rdata, 16'h00FF);

        // Rising edge on lane 0: DATA_IN after edge n+1, status/irq after edge n+2.
        do_write(3'd3, 16'h0001);
        pad_y = 15'h0001;
        cycles(1);
        check("edge_n_irq", {15'b0, irq}, 16'h0000);
        rd_en = 1'b1; addr = 3'd2;
        cycles(1);
        check("data_in_at_n1", rdata, 16'h0000);
        check("edge_n1_irq", {15'b0, irq}, 16'h0000);
        cycles(1);
        rd_en = 1'b0;
        check("data_in_at_n2", rdata, 16'h0001);
        check("edge_n2_irq", {15'b0, irq}, 16'h0001);
        do_read(3'd4);
        check("status_set", rdata, 16'h0001);
        do_write(3'd4, 16'h0001);
        check("w1c_irq", {15'b0, irq}, 16'h0000);
        do_read(3'd4);
        check("w1c_status", rdata, 16'h0000);

        // Falling edge on a rising-select lane must not set.
        pad_y = 15'h0000;
        cycles(4);
        do_read(3'd4);
        check("fall_ignored", rdata, 16'h0000);
        // Lane 1 selects falling and is not enabled for irq.
        pad_y = 15'h0002;
        cycles(4);
        do_read(3'd4);
        check("lane1_rise_ignored", rdata, 16'h0000);
        pad_y = 15'h0000;
        cycles(4);
        do_read(3'd4);
        check("lane1_fall_set", rdata, 16'h0002);
        check("lane1_no_irq", {15'b0, irq}, 16'h0000);
        do_write(3'd4, 16'h0002);
        do_read(3'd4);
        check("lane1_cleared", rdata, 16'h0000);

        // W1C landing on the same edge as a new set: the set must win.
        pad_y = 15'h0001;
        cycles(2);
        do_write(3'd4, 16'h0001);
        check("set_wins_irq", {15'b0, irq}, 16'h0001);
        do_read(3'd4);
        check("set_wins_status", rdata, 16'h0001);

        // Test mode: walking ones, status frozen, registers still accessible.
        do_write(3'd5, 16'h00FF);
        tm = 1'b1;
        cycles(1);
        check("tm_sync_delay_oe", {1'b0, pad_oe}, 16'h00FF);
        cycles(1);
        exp_pat = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("tm_pat%0d", i), {1'b0, pad_a}, exp_pat);
            check($sformatf("tm_oe%0d", i), {1'b0, pad_oe}, 16'h7FFF);
            if (i == 2) pad_y = 15'h0009;
            cycles(1);
            exp_pat = rotl15(exp_pat);
        end
        do_read(3'd4);
        check("tm_status_frozen", rdata, 16'h0001);
        do_read(3'd2);
        check("tm_data_in", rdata, 16'h0009);
        check("tm_irq", {15'b0, irq}, 16'h0001);
        tm = 1'b0;
        cycles(1);
        check("tm_exit_delay_oe", {1'b0, pad_oe}, 16'h7FFF);
        cycles(1);
        check("tm_exit_oe", {1'b0, pad_oe}, 16'h00FF);
        check("tm_exit_pad_a", {1'b0, pad_a}, 16'h0055);
        cycles(3);
        do_read(3'd4);
        check("post_tm_status", rdata, 16'h0001);

        // Read of an unmapped address, then read/write collision on DIR.
        do_read(3'd6);
        check("rd6_rdata", rdata, 16'h0000);
        check("rd6_valid", {15'b0, rd_valid}, 16'h0001);
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd1; wdata = 16'h0003;
        cycles(1);
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdwr_old_dir", rdata, 16'h00FF);
        check("rdwr_valid", {15'b0, rd_valid}, 16'h0001);
        check("rdwr_new_oe", {1'b0, pad_oe}, 16'h0003);
        cycles(1);
        check("rdwr_valid_drop", {15'b0, rd_valid}, 16'h0000);
        check("rdwr_rdata_hold", rdata, 16'h00FF);

        // Asynchronous reset in the middle of test mode.
        tm = 1'b1;
        cycles(5);
        check("tm2_pattern", {1'b0, pad_a}, 16'h0008);
        check("tm2_irq", {15'b0, irq}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pad_a", {1'b0, pad_a}, 16'h0000);
        check("async_rst_pad_oe", {1'b0, pad_oe}, 16'h0000);
        check("async_rst_irq", {15'b0, irq}, 16'h0000);
        check("async_rst_rdata", rdata, 16'h0000);
        check("async_rst_rd_valid", {15'b0, rd_valid}, 16'h0000);
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("rel_tm_delay_oe", {1'b0, pad_oe}, 16'h0000);
        cycles(1);
        check("rel_pat_first", {1'b0, pad_a}, 16'h0001);
        check("rel_oe", {1'b0, pad_oe}, 16'h7FFF);
        cycles(1);
        check("rel_pat_second", {1'b0, pad_a}, 16'h0002);
        tm = 1'b0;
        cycles(3);
        check("rel_exit_pad_a", {1'b0, pad_a}, 16'h0000);
        check("rel_exit_pad_oe", {1'b0, pad_oe}, 16'h0000);
        do_read(3'd1);
        check("rel_dir", rdata, 16'h0000);
        do_read(3'd2);
        check("rel_data_in", rdata, 16'h0009);
        do_read(3'd4);
        check("rel_status", rdata, 16'h0000);
        check("rel_irq", {15'b0, irq}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
